// File: rtl/demux_1in_3out.sv
// demux_1in_3out: routes one valid/ready input stream to one of three
// single-entry output slots (A, B, C) chosen by Sel. Sel=3 is an illegal
// destination: the word is accepted and dropped, a sticky error flag is set
// and a saturating drop counter is incremented.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   DatoIn, Sel     word to route and its destination (0=A, 1=B, 2=C, 3=drop)
//   ValidIn         DatoIn/Sel are valid this cycle
//   ReadyIn         block accepts the presented word this cycle
//   DatoX, ValidX   holding register contents / occupancy for X in {A,B,C}
//   ReadyX          consumer of X accepts the held word
//   ErrSel          sticky: a word with Sel=3 was accepted
//   CuentaDescartes saturating count of words dropped for Sel=3
module demux_1in_3out #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] DatoIn,
  input  logic [1:0]       Sel,
  input  logic             ValidIn,
  output logic             ReadyIn,
  output logic [WIDTH-1:0] DatoA,
  output logic [WIDTH-1:0] DatoB,
  output logic [WIDTH-1:0] DatoC,
  output logic             ValidA,
  output logic             ValidB,
  output logic             ValidC,
  input  logic             ReadyA,
  input  logic             ReadyB,
  input  logic             ReadyC,
  output logic             ErrSel,
  output logic [7:0]       CuentaDescartes
);

  localparam int unsigned NumSlots = 3;

  logic [WIDTH-1:0] dat_q [NumSlots];
  logic [2:0]       val_q;
  logic [2:0]       rdy_out;
  logic [2:0]       load;
  logic [2:0]       drain;
  logic             in_xfer;
  logic             drop;
  logic             err_q;
  logic [7:0]       cnt_q;

  assign rdy_out = {ReadyC, ReadyB, ReadyA};

  // Slot can take a word when empty or when it is being drained this edge.
  // Independent of ValidIn so upstream may wait on ReadyIn without deadlock.
  always_comb begin
    ReadyIn = 1'b1;
    unique case (Sel)
      2'd0:    ReadyIn = ~val_q[0] | rdy_out[0];
      2'd1:    ReadyIn = ~val_q[1] | rdy_out[1];
      2'd2:    ReadyIn = ~val_q[2] | rdy_out[2];
      default: ReadyIn = 1'b1;
    endcase
  end

  assign in_xfer = ValidIn & ReadyIn;
  assign drop    = in_xfer & (Sel == 2'd3);

  always_comb begin
    load  = '0;
    drain = '0;
    for (int i = 0; i < NumSlots; i++) begin
      load[i]  = in_xfer & (Sel == 2'(i));
      drain[i] = val_q[i] & rdy_out[i];
    end
  end

  // A load on the same edge as a drain replaces the word and keeps the slot
  // valid, so the old word leaves and the new one arrives without a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumSlots; i++) begin
        dat_q[i] <= '0;
      end
      val_q <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (load[i]) begin
          dat_q[i] <= DatoIn;
          val_q[i] <= 1'b1;
        end else if (drain[i]) begin
          val_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (drop) begin
      err_q <= 1'b1;
      if (cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign DatoA           = dat_q[0];
  assign DatoB           = dat_q[1];
  assign DatoC           = dat_q[2];
  assign ValidA          = val_q[0];
  assign ValidB          = val_q[1];
  assign ValidC          = val_q[2];
  assign ErrSel          = err_q;
  assign CuentaDescartes = cnt_q;

endmodule

// File: tb/tb_demux_1in_3out.sv
// Bench for demux_1in_3out: directed scenarios followed by random traffic,
// all checked against a slot-level behavioural model.
module tb_demux_1in_3out;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] DatoIn;
  logic [1:0]   Sel;
  logic         ValidIn;
  logic         ReadyIn;
  logic [W-1:0] DatoA, DatoB, DatoC;
  logic         ValidA, ValidB, ValidC;
  logic         ReadyA, ReadyB, ReadyC;
  logic         ErrSel;
  logic [7:0]   CuentaDescartes;

  demux_1in_3out #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .DatoIn          (DatoIn),
    .Sel             (Sel),
    .ValidIn         (ValidIn),
    .ReadyIn         (ReadyIn),
    .DatoA           (DatoA),
    .DatoB           (DatoB),
    .DatoC           (DatoC),
    .ValidA          (ValidA),
    .ValidB          (ValidB),
    .ValidC          (ValidC),
    .ReadyA          (ReadyA),
    .ReadyB          (ReadyB),
    .ReadyC          (ReadyC),
    .ErrSel          (ErrSel),
    .CuentaDescartes (CuentaDescartes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what each slot holds, plus the error/drop bookkeeping.
  logic [W-1:0] m_dat [3];
  bit           m_val [3];
  bit           m_err;
  int           m_cnt;

  int checks   = 0;
  int failures = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_dat[i] = '0;
      m_val[i] = 0;
    end
    m_err = 0;
    m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " DatoA"}, DatoA, m_dat[0]);
    chk({tag, " DatoB"}, DatoB, m_dat[1]);
    chk({tag, " DatoC"}, DatoC, m_dat[2]);
    chk({tag, " ValidA"}, W'(ValidA), W'(m_val[0]));
    chk({tag, " ValidB"}, W'(ValidB), W'(m_val[1]));
    chk({tag, " ValidC"}, W'(ValidC), W'(m_val[2]));
    chk({tag, " ErrSel"}, W'(ErrSel), W'(m_err));
    chk({tag, " Cuenta"}, W'(CuentaDescartes), W'(m_cnt));
  endtask

  // One clock cycle, entered and left at the falling edge.
  // rdy = {ReadyC, ReadyB, ReadyA}.
  task automatic cyc(input string tag, input logic [W-1:0] d, input int s, input bit v,
                     input bit [2:0] rdy);
    bit exp_rdy;
    bit accept;
    DatoIn  = d;
    Sel     = 2'(s);
    ValidIn = v;
    {ReadyC, ReadyB, ReadyA} = rdy;
    #1;
    exp_rdy = (s == 3) ? 1'b1 : (!m_val[s] || rdy[s]);
    chk({tag, " ReadyIn"}, W'(ReadyIn), W'(exp_rdy));
    @(posedge clk);
    accept = v && exp_rdy;
    for (int i = 0; i < 3; i++) begin
      if (accept && s == i) begin
        m_dat[i] = d;
        m_val[i] = 1;
      end else if (m_val[i] && rdy[i]) begin
        m_val[i] = 0;
      end
    end
    if (accept && s == 3) begin
      m_err = 1;
      if (m_cnt < 255) m_cnt++;
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks the immediate asynchronous effect.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs({tag, " async"});
    for (int s = 0; s < 4; s++) begin
      Sel = 2'(s);
      #1;
      chk({tag, " ReadyIn in reset"}, W'(ReadyIn), W'(1));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    DatoIn  = '0;
    Sel     = 2'd0;
    ValidIn = 1'b0;
    ReadyA  = 1'b1;
    ReadyB  = 1'b1;
    ReadyC  = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset("init");

    // Basic routing: each word appears one cycle after its input and drains.
    cyc("route2", 2, 0, 1, 3'b111);
    cyc("route4", 4, 1, 1, 3'b111);
    cyc("route6", 6, 2, 1, 3'b111);
    cyc("route_idle", 0, 0, 0, 3'b111);

    // Backpressure on B, then simultaneous drain and load.
    cyc("bp_load4", 4, 1, 1, 3'b101);
    cyc("bp_stall8", 8, 1, 1, 3'b101);
    cyc("bp_stall8b", 8, 1, 1, 3'b101);
    cyc("bp_swap", 8, 1, 1, 3'b111);
    cyc("bp_drain", 0, 1, 0, 3'b111);

    // Independence: A full and stalled while C flows.
    cyc("ind_fillA", 32'h11, 0, 1, 3'b110);
    cyc("ind_sendC", 6, 2, 1, 3'b110);
    cyc("ind_hold", 0, 2, 0, 3'b110);
    cyc("ind_drainA", 0, 0, 0, 3'b111);

    // Illegal select: drops, sticky flag, saturating count.
    for (int i = 0; i < 3; i++) cyc("illegal3", W'(i + 100), 3, 1, 3'b111);
    for (int i = 0; i < 300; i++) cyc("illegal_sat", W'(i), 3, 1, 3'b111);
    chk("sat_final", W'(CuentaDescartes), W'(255));

    // Reset mid-operation with A and C full and stalled.
    cyc("mid_fillA", 32'hAA, 0, 1, 3'b000);
    cyc("mid_fillC", 32'hCC, 2, 1, 3'b000);
    do_reset("mid_reset");
    cyc("post_reset", 2, 0, 1, 3'b111);
    chk("post_reset DatoA", DatoA, W'(2));

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cyc("rand", W'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0),
          3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
